// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned, one multiplier bit per cycle.
// Latency: start sampled at edge k -> done pulses in the cycle after edge k+WIDTH+3.
// Backpressure: none; start is accepted only in IDLE and ignored while busy (no queuing).
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             long_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam int             PW       = 2 * WIDTH;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  ma_q, ma_d;       // multiplicand (operand, then magnitude)
    logic [WIDTH-1:0]  mb_q, mb_d;       // multiplier, consumed LSB first
    logic [PW-1:0]     acc_q, acc_d;     // {acc_hi, acc_lo}; product forms from the top down
    logic              neg_q, neg_d;
    logic              sgn_q, sgn_d;
    logic              long_q, long_d;
    logic [WIDTH-1:0]  res_lo_q, res_lo_d;
    logic [WIDTH-1:0]  res_hi_q, res_hi_d;

    logic [WIDTH:0]    sum;              // WIDTH+1 bits so the carry feeds the shift
    logic [WIDTH-1:0]  addend;
    logic [PW-1:0]     prod;

    // Next-state, datapath and status decode for the multiply sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        sgn_d    = sgn_q;
        long_d   = long_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        addend   = '0;
        sum      = '0;
        prod     = '0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ma_d    = a;
                    mb_d    = b;
                    sgn_d   = is_signed;
                    long_d  = long_en;
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                busy = 1'b1;
                // The most negative value negates to itself, which is its
                // correct magnitude when read as unsigned.
                ma_d    = (sgn_q && ma_q[WIDTH-1]) ? (~ma_q + WIDTH'(1)) : ma_q;
                mb_d    = (sgn_q && mb_q[WIDTH-1]) ? (~mb_q + WIDTH'(1)) : mb_q;
                neg_d   = sgn_q & (ma_q[WIDTH-1] ^ mb_q[WIDTH-1]);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    addend = mb_q[0] ? ma_q : '0;
                    sum    = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend};
                    // Shift {carry, acc_hi, acc_lo} right by one; acc_lo[0] drops out.
                    acc_d  = {sum, acc_q[WIDTH-1:1]};
                    mb_d   = {1'b0, mb_q[WIDTH-1:1]};
                    cnt_d  = cnt_q + CW'(1);
                end
            end

            S_FIX: begin
                busy     = 1'b1;
                prod     = neg_q ? (~acc_q + PW'(1)) : acc_q;
                res_lo_d = prod[WIDTH-1:0];
                res_hi_d = long_q ? prod[PW-1:WIDTH] : '0;
                state_d  = S_DONE;
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                // Illegal encoding: recover to IDLE with outputs at reset values.
                res_lo_d = '0;
                res_hi_d = '0;
                cnt_d    = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            sgn_q    <= 1'b0;
            long_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            sgn_q    <= sgn_d;
            long_q   <= long_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: hand-computed products, latency, done pulse width,
// start-while-busy rejection and asynchronous reset abort.
module tb_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic        long_en;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;

    int checks = 0;
    int errors = 0;

    mul_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .long_en   (long_en),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full operation: start pulse, latency count, result and pulse-width checks.
    task automatic run_op(input string tag, input logic sgn, input logic lng,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        a         = av;
        b         = bv;
        is_signed = sgn;
        long_en   = lng;
        start     = 1'b1;
        @(posedge clk);            // start edge k
        #1;
        start     = 1'b0;
        // Operands are don't-care after capture.
        a         = ~av;
        b         = ~bv;
        is_signed = ~sgn;
        long_en   = ~lng;
        chk({tag, "_busy_start"}, {63'd0, busy}, 64'd1);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        chk({tag, "_latency"}, 64'(n), 64'd35);
        chk({tag, "_hi"}, {32'd0, result_hi}, {32'd0, ehi});
        chk({tag, "_lo"}, {32'd0, result_lo}, {32'd0, elo});
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        chk({tag, "_lo_hold"}, {32'd0, result_lo}, {32'd0, elo});
    endtask

    initial begin
        int dones;
        int bad_busy;
        logic [31:0] lo_at;

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        long_en   = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_lo", {32'd0, result_lo}, 64'd0);
        chk("rst_hi", {32'd0, result_hi}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // T1..T4 and extra directed vectors
        run_op("t1_u7x6",      1'b0, 1'b1, 32'd7,        32'd6,        32'h00000000, 32'h0000002A);
        run_op("t2_sm3x5",     1'b1, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("t3_umax",      1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("t3_smin",      1'b1, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("t4_short",     1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000);
        run_op("s_m7xm6",      1'b1, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h00000000, 32'h0000002A);
        run_op("s_maxxmin",    1'b1, 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
        run_op("s_short_neg",  1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF);
        run_op("u_neg_as_uns", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1);
        run_op("zero_op",      1'b0, 1'b1, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000);

        // T5: start while busy (mid-RUN and in DONE) must be ignored
        a         = 32'd3;
        b         = 32'd4;
        is_signed = 1'b0;
        long_en   = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dones    = 0;
        bad_busy = 0;
        lo_at    = '0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                lo_at = result_lo;
            end
            if (c <= 35 && !busy) bad_busy++;
            if (c > 35 && busy) bad_busy++;
            start = (c == 10) || (c == 35);
            if (c == 10) begin
                a         = 32'd5;
                b         = 32'd9;
                is_signed = 1'b1;
            end
        end
        start = 1'b0;
        chk("t5_done_count", 64'(dones), 64'd1);
        chk("t5_lo", {32'd0, lo_at}, 64'd12);
        chk("t5_busy_profile", 64'(bad_busy), 64'd0);
        chk("t5_lo_hold", {32'd0, result_lo}, 64'd12);

        // T6: asynchronous reset in the middle of RUN
        a         = 32'd9;
        b         = 32'd7;
        is_signed = 1'b0;
        long_en   = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("t6_busy_run", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_busy_abort", {63'd0, busy}, 64'd0);
        chk("t6_done_abort", {63'd0, done}, 64'd0);
        chk("t6_lo_abort", {32'd0, result_lo}, 64'd0);
        chk("t6_hi_abort", {32'd0, result_hi}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t6_busy_held", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        run_op("t6_after", 1'b0, 1'b1, 32'd9, 32'd7, 32'h00000000, 32'h0000003F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
